// File: rtl/csm_mult_arbiter.sv
// Round-robin sequencer in front of one shared carry-save multiplier serving two requesters.
// Define CSM_MULT_ARB_STATS_EN to add saturating per-requester accept counters (o_count0/o_count1).

module carry_save_multiplier #(
    parameter int N = 8
) (
    input  logic [N-1:0]   i_m,
    input  logic [N-1:0]   i_q,
    output logic [2*N-1:0] o_p
);
    localparam int PW = 2 * N;

    logic [PW-1:0] pp      [N];
    logic [PW-1:0] sum_w   [N];
    logic [PW-1:0] carry_w [N];
    logic [PW-1:0] rc;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_pp
            assign pp[i] = {{N{1'b0}}, i_m & {N{i_q[i]}}} << i;
        end
    endgenerate

    assign sum_w[0]   = pp[0];
    assign carry_w[0] = '0;

    // Each row folds one partial product into the redundant sum/carry pair without propagating carries.
    generate
        for (i = 1; i < N; i++) begin : g_csa
            assign sum_w[i]   = sum_w[i-1] ^ carry_w[i-1] ^ pp[i];
            assign carry_w[i] = ((sum_w[i-1] & carry_w[i-1]) |
                                 (sum_w[i-1] & pp[i]) |
                                 (carry_w[i-1] & pp[i])) << 1;
        end
    endgenerate

    // Vector-merging ripple adder; the carry out of the top bit is always zero for an NxN product.
    assign rc[0] = 1'b0;
    generate
        for (i = 0; i < PW; i++) begin : g_vma
            assign o_p[i] = sum_w[N-1][i] ^ carry_w[N-1][i] ^ rc[i];
            if (i < PW - 1) begin : g_c
                assign rc[i+1] = (sum_w[N-1][i] & carry_w[N-1][i]) |
                                 (sum_w[N-1][i] & rc[i]) |
                                 (carry_w[N-1][i] & rc[i]);
            end
        end
    endgenerate
endmodule

module csm_mult_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_req0_valid,
    input  logic [N-1:0]   i_req0_m,
    input  logic [N-1:0]   i_req0_q,
    output logic           o_req0_ready,
    input  logic           i_req1_valid,
    input  logic [N-1:0]   i_req1_m,
    input  logic [N-1:0]   i_req1_q,
    output logic           o_req1_ready,
    output logic           o_resp_valid,
    output logic           o_resp_id,
    output logic [2*N-1:0] o_resp_p,
    input  logic           i_resp_ready
`ifdef CSM_MULT_ARB_STATS_EN
    ,
    output logic [15:0]    o_count0,
    output logic [15:0]    o_count1
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [N-1:0]   op_m_q, op_m_d;
    logic [N-1:0]   op_q_q, op_q_d;
    logic           op_id_q, op_id_d;
    logic           resp_valid_q, resp_valid_d;
    logic           resp_id_q, resp_id_d;
    logic [2*N-1:0] resp_p_q, resp_p_d;
    logic [2*N-1:0] mul_p;
    logic           grant0, grant1;

    carry_save_multiplier #(.N(N)) u_mult (
        .i_m (op_m_q),
        .i_q (op_q_q),
        .o_p (mul_p)
    );

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant0 = (state_q == S_IDLE) && i_req0_valid && (!i_req1_valid || last_grant_q);
        grant1 = (state_q == S_IDLE) && i_req1_valid && (!i_req0_valid || !last_grant_q);
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_id    = resp_id_q;
    assign o_resp_p     = resp_p_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_m_d       = op_m_q;
        op_q_d       = op_q_q;
        op_id_d      = op_id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_p_d     = resp_p_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    op_m_d       = grant1 ? i_req1_m : i_req0_m;
                    op_q_d       = grant1 ? i_req1_q : i_req0_q;
                    op_id_d      = grant1;
                    last_grant_d = grant1;
                    state_d      = S_MUL;
                end
            end
            S_MUL: begin
                resp_p_d     = mul_p;
                resp_id_d    = op_id_q;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (i_resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            op_m_q       <= '0;
            op_q_q       <= '0;
            op_id_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_p_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_m_q       <= op_m_d;
            op_q_q       <= op_q_d;
            op_id_q      <= op_id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_p_q     <= resp_p_d;
        end
    end

`ifdef CSM_MULT_ARB_STATS_EN
    logic [15:0] count0_q, count0_d;
    logic [15:0] count1_q, count1_d;

    always_comb begin
        count0_d = count0_q;
        count1_d = count1_q;
        if (grant0 && count0_q != 16'hFFFF) count0_d = count0_q + 16'd1;
        if (grant1 && count1_q != 16'hFFFF) count1_d = count1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count0_q <= '0;
            count1_q <= '0;
        end else begin
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    assign o_count0 = count0_q;
    assign o_count1 = count1_q;
`endif
endmodule

// File: tb/tb_csm_mult_arbiter.sv
// Scoreboard bench for csm_mult_arbiter: accepts push expected products, consumer accepts pop and compare.
// Counter checks are included when CSM_MULT_ARB_STATS_EN is defined.

module tb_csm_mult_arbiter;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_req0_valid, i_req1_valid;
    logic [N-1:0]   i_req0_m, i_req0_q, i_req1_m, i_req1_q;
    logic           o_req0_ready, o_req1_ready;
    logic           o_resp_valid, o_resp_id;
    logic [2*N-1:0] o_resp_p;
    logic           i_resp_ready;
`ifdef CSM_MULT_ARB_STATS_EN
    logic [15:0]    o_count0, o_count1;
`endif

    always #5 clk = ~clk;

    csm_mult_arbiter #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req0_valid (i_req0_valid),
        .i_req0_m     (i_req0_m),
        .i_req0_q     (i_req0_q),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_m     (i_req1_m),
        .i_req1_q     (i_req1_q),
        .o_req1_ready (o_req1_ready),
        .o_resp_valid (o_resp_valid),
        .o_resp_id    (o_resp_id),
        .o_resp_p     (o_resp_p),
        .i_resp_ready (i_resp_ready)
`ifdef CSM_MULT_ARB_STATS_EN
        ,
        .o_count0     (o_count0),
        .o_count1     (o_count1)
`endif
    );

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [16:0] sb[$];
    bit          grant_log[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model_mul(input logic [7:0] m, input logic [7:0] q);
        logic [15:0] a, b;
        a = {8'b0, m};
        b = {8'b0, q};
        return a * b;
    endfunction

    // Monitor samples mid-cycle; inputs change just after the rising edge.
    always @(negedge clk) begin : mon
        logic [16:0] e;
        if (reset) begin
            sb.delete();
        end else begin
            if (o_req0_ready && o_req1_ready) check_val("both_ready", 32'd1, 32'd0);
            if (i_req0_valid && o_req0_ready) begin
                sb.push_back({1'b0, model_mul(i_req0_m, i_req0_q)});
                grant_log.push_back(1'b0);
            end
            if (i_req1_valid && o_req1_ready) begin
                sb.push_back({1'b1, model_mul(i_req1_m, i_req1_q)});
                grant_log.push_back(1'b1);
            end
            if (o_resp_valid && i_resp_ready) begin
                if (sb.size() == 0) begin
                    check_val("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("resp_id", {31'b0, o_resp_id}, {31'b0, e[16]});
                    check_val("resp_p", {16'b0, o_resp_p}, {16'b0, e[15:0]});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic drain();
        int n = 0;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        i_resp_ready = 1'b1;
        while ((sb.size() != 0 || o_resp_valid) && n < 20) begin
            cyc();
            n++;
        end
        check_val("drain_sb_empty", sb.size(), 32'd0);
        check_val("drain_valid_low", {31'b0, o_resp_valid}, 32'd0);
    endtask

    task automatic do_req(input bit id, input logic [7:0] m, input logic [7:0] q);
        int n = 0;
        i_resp_ready = 1'b1;
        if (id) begin
            i_req1_valid = 1'b1; i_req1_m = m; i_req1_q = q;
        end else begin
            i_req0_valid = 1'b1; i_req0_m = m; i_req0_q = q;
        end
        #1;
        while (!(id ? o_req1_ready : o_req0_ready) && n < 20) begin
            cyc();
            n++;
        end
        check_val("req_grant_wait", {31'b0, n < 20}, 32'd1);
        cyc();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        cycles(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a0, a1;
        int n;
        reset = 1'b1;
        i_req0_valid = 1'b0; i_req0_m = '0; i_req0_q = '0;
        i_req1_valid = 1'b0; i_req1_m = '0; i_req1_q = '0;
        i_resp_ready = 1'b0;
        cycles(3);
        check_val("rst_resp_valid", {31'b0, o_resp_valid}, 32'd0);
        reset = 1'b0;

        // Idle after reset
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_val("idle_ready0", {31'b0, o_req0_ready}, 32'd0);
            check_val("idle_ready1", {31'b0, o_req1_ready}, 32'd0);
            check_val("idle_valid", {31'b0, o_resp_valid}, 32'd0);
            check_val("idle_id", {31'b0, o_resp_id}, 32'd0);
            check_val("idle_p", {16'b0, o_resp_p}, 32'd0);
        end

        // Single request 13 x 11
        i_req0_valid = 1'b1; i_req0_m = 8'd13; i_req0_q = 8'd11;
        #1;
        check_val("single_ready0", {31'b0, o_req0_ready}, 32'd1);
        check_val("single_ready1", {31'b0, o_req1_ready}, 32'd0);
        cyc();
        i_req0_valid = 1'b0; i_req0_m = 8'hAA;
        #1;
        check_val("single_mul_valid", {31'b0, o_resp_valid}, 32'd0);
        check_val("single_mul_ready0", {31'b0, o_req0_ready}, 32'd0);
        cyc();
        check_val("single_valid", {31'b0, o_resp_valid}, 32'd1);
        check_val("single_p", {16'b0, o_resp_p}, 32'd143);
        check_val("single_id", {31'b0, o_resp_id}, 32'd0);
        i_resp_ready = 1'b1;
        cyc();
        check_val("single_clear", {31'b0, o_resp_valid}, 32'd0);
        i_resp_ready = 1'b0;

        // Tie from reset: grants must alternate starting with requester 0
        reset = 1'b1;
        i_req0_valid = 1'b1; i_req0_m = 8'd255; i_req0_q = 8'd255;
        i_req1_valid = 1'b1; i_req1_m = 8'd2;   i_req1_q = 8'd3;
        i_resp_ready = 1'b1;
        cycles(2);
        grant_log.delete();
        reset = 1'b0;
        n = 0;
        while (grant_log.size() < 6 && n < 60) begin
            cyc();
            n++;
        end
        check_val("tie_grants", grant_log.size(), 32'd6);
        for (int k = 0; k < grant_log.size(); k++)
            check_val($sformatf("tie_grant%0d", k), {31'b0, grant_log[k]}, k % 2);
        drain();

        // Back-pressure with req1 waiting
        i_resp_ready = 1'b0;
        i_req0_valid = 1'b1; i_req0_m = 8'd200; i_req0_q = 8'd50;
        cyc();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b1; i_req1_m = 8'd7; i_req1_q = 8'd9;
        #1;
        check_val("bp_mul_ready1", {31'b0, o_req1_ready}, 32'd0);
        cyc();
        for (int k = 0; k < 10; k++) begin
            check_val("bp_valid", {31'b0, o_resp_valid}, 32'd1);
            check_val("bp_p", {16'b0, o_resp_p}, 32'd10000);
            check_val("bp_ready1", {31'b0, o_req1_ready}, 32'd0);
            cyc();
        end
        i_resp_ready = 1'b1;
        #1;
        check_val("bp_no_ready_path", {31'b0, o_req1_ready}, 32'd0);
        cyc();
        check_val("bp_release_ready1", {31'b0, o_req1_ready}, 32'd1);
        check_val("bp_release_valid", {31'b0, o_resp_valid}, 32'd0);
        cyc();
        i_req1_valid = 1'b0; i_req1_m = 8'hFF; i_req1_q = 8'hFF;
        drain();

        // Reset while in MUL
        i_resp_ready = 1'b0;
        i_req0_valid = 1'b1; i_req0_m = 8'd5; i_req0_q = 8'd5;
        cyc();
        i_req0_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_val("rst_mul_no_resp", {31'b0, o_resp_valid}, 32'd0);
            cyc();
        end

        // Reset while in RESP
        i_req1_valid = 1'b1; i_req1_m = 8'd9; i_req1_q = 8'd9;
        cyc();
        i_req1_valid = 1'b0;
        cyc();
        check_val("rst_resp_pre_valid", {31'b0, o_resp_valid}, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        grant_log.delete();
        check_val("rst_resp_valid", {31'b0, o_resp_valid}, 32'd0);
        check_val("rst_resp_p", {16'b0, o_resp_p}, 32'd0);
        check_val("rst_resp_id", {31'b0, o_resp_id}, 32'd0);

        // First tie after reset goes to requester 0, then completes normally
        i_req0_valid = 1'b1; i_req0_m = 8'd17; i_req0_q = 8'd19;
        i_req1_valid = 1'b1; i_req1_m = 8'd0;  i_req1_q = 8'd77;
        i_resp_ready = 1'b1;
        n = 0;
        while (grant_log.size() < 2 && n < 20) begin
            cyc();
            n++;
        end
        check_val("post_rst_grants", grant_log.size(), 32'd2);
        if (grant_log.size() > 0) check_val("post_rst_first", {31'b0, grant_log[0]}, 32'd0);
        drain();

        // Random traffic honouring the hold-until-accepted rule
        for (int k = 0; k < 120; k++) begin
            i_resp_ready = 1'($urandom_range(0, 1));
            #1;
            a0 = i_req0_valid && o_req0_ready;
            a1 = i_req1_valid && o_req1_ready;
            cyc();
            if (!i_req0_valid || a0) begin
                i_req0_valid = 1'($urandom_range(0, 1));
                i_req0_m = 8'($urandom);
                i_req0_q = 8'($urandom);
            end
            if (!i_req1_valid || a1) begin
                i_req1_valid = 1'($urandom_range(0, 1));
                i_req1_m = 8'($urandom);
                i_req1_q = 8'($urandom);
            end
        end
        drain();

`ifdef CSM_MULT_ARB_STATS_EN
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        check_val("cnt0_reset", {16'b0, o_count0}, 32'd0);
        do_req(1'b0, 8'd1, 8'd2);
        do_req(1'b1, 8'd3, 8'd4);
        do_req(1'b0, 8'd5, 8'd6);
        do_req(1'b1, 8'd7, 8'd8);
        do_req(1'b0, 8'd9, 8'd10);
        check_val("cnt0", {16'b0, o_count0}, 32'd3);
        check_val("cnt1", {16'b0, o_count1}, 32'd2);
        force dut.count0_q = 16'hFFFF;
        cyc();
        release dut.count0_q;
        do_req(1'b0, 8'd11, 8'd12);
        check_val("cnt0_sat", {16'b0, o_count0}, 32'hFFFF);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/csm_mult_arbiter.md
# csm_mult_arbiter

Arbitrated sequencer for one shared `carry_save_multiplier` (N×N unsigned, 2N-bit product) serving two requesters.
- Registers the granted operands, drives them into the multiplier, and captures the product one cycle later.
- Holds the product in a response register until the consumer accepts it.
- Sits between the two datapath masters and the single multiplier instance, which it instantiates internally.

## Interface
Parameters:
- N, 8, operand width; product width is 2N.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- i_req0_valid  input  1  requester 0 has operands
- i_req0_m  input  N  requester 0 multiplicand
- i_req0_q  input  N  requester 0 multiplier
- o_req0_ready  output  1  requester 0 operands accepted this cycle if valid
- i_req1_valid  input  1  requester 1 has operands
- i_req1_m  input  N  requester 1 multiplicand
- i_req1_q  input  N  requester 1 multiplier
- o_req1_ready  output  1  requester 1 operands accepted this cycle if valid
- o_resp_valid  output  1  response register holds a product
- o_resp_id  output  1  requester that issued the held product
- o_resp_p  output  2N  product i_m × i_q, unsigned
- i_resp_ready  input  1  consumer accepts response this cycle

## Operation
- States:
  - IDLE: no operation in flight.
  - MUL: operands registered; multiplier settling.
  - RESP: product held.
- IDLE:
  - Grant: if exactly one requester is valid, grant it.
  - If both are valid, grant the requester not in last_grant (round-robin).
  - The granted requester's ready is asserted; the other's is 0.
  - On grant: capture m and q into op registers, capture id, set last_grant to id, go to MUL.
  - Neither valid: stay IDLE, both readies 0.
- MUL: the multiplier sees the op registers. At the edge, capture the product into o_resp_p, set o_resp_valid, go to RESP.
- RESP:
  - o_resp_valid=1; o_resp_p and o_resp_id stable.
  - On i_resp_ready=1, clear o_resp_valid at the edge and go to IDLE.
  - Otherwise hold indefinitely; no new request is accepted.
- Readies are 0 in MUL and RESP.
- Readies depend on state, last_grant and the two valid inputs only; there is no path from i_resp_ready to either ready.
- Requester operands need only be stable in the accept cycle. Later changes have no effect on the in-flight product.
- Arithmetic: full unsigned 2N-bit product, no truncation. 0×x=0; (2^N−1)² = 2^2N − 2^(N+1) + 1.
- Reset behaviour:
  - Reset takes priority over every other event: state IDLE, last_grant=1 (requester 0 wins first tie), op registers 0.
  - A reset asserted in MUL or RESP discards the operation; no response is produced.

## Timing
- Reset values: o_req0_ready=0, o_req1_ready=0, o_resp_valid=0, o_resp_id=0, o_resp_p=0.
- Accept at edge k (valid&ready): o_resp_valid=1 after edge k+1. Latency is 1 cycle from accept to valid response.
- Response accepted at edge r: the block is back in IDLE after r, and the next grant can occur in cycle r+1. Peak throughput is one product per 3 cycles.
- A requester holding valid without ready keeps valid and operands stable; the block never drops an asserted request.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…
- Multiplier combinational path: op register → o_resp_p register, one full cycle.

## Configuration
- Macro `CSM_MULT_ARB_STATS_EN`.
- Defined:
  - Adds outputs o_count0 and o_count1, each 16 bits.
  - Each counts accepted requests per requester, incrementing at the accept edge.
  - Both reset to 0, saturate at 0xFFFF, and are unaffected by response back-pressure.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, readies 0.
- Single request: req0 m=8'd13 q=8'd11 → o_req0_ready=1 in cycle 0; o_resp_valid=1 with p=16'd143, id=0 after edge 1; i_resp_ready=1 → valid clears.
- Tie: both valid from reset (req0 255×255, req1 2×3), consumer always ready → first response id=0 p=16'hFE01, second id=1 p=16'd6; grants alternate across 4 further back-to-back ties.
- Back-pressure: hold i_resp_ready=0 for 10 cycles with req1 valid → p stable, o_req1_ready stays 0; release → req1 granted in the cycle after response accept.
- Mid-operation reset in MUL and in RESP → no response appears; the next request completes normally; the first tie after reset goes to requester 0.
- With `CSM_MULT_ARB_STATS_EN`: 3 accepts from req0 and 2 from req1 → o_count0=3, o_count1=2; a preloaded/forced 0xFFFF count does not wrap on the next accept.
